// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder from 1-bit full-adder cells, with a registered copy of the result.
// Optional signed-overflow output is enabled with `define FULL_ADDER_OVERFLOW_EN.

module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_out_q
`ifdef FULL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_sum_q;
  logic             r_carry_out_q;

  assign w_c[0] = carry_in;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    full_adder_cell u_cell (
      .i_a (a[gi]),
      .i_b (b[gi]),
      .i_c (w_c[gi]),
      .o_s (w_s[gi]),
      .o_c (w_c[gi+1])
    );
  end

  assign sum       = w_s;
  assign carry_out = w_c[WIDTH];

`ifdef FULL_ADDER_OVERFLOW_EN
  // Carry into the sign bit differing from carry out of it marks two's-complement overflow.
  assign overflow = w_c[WIDTH] ^ w_c[WIDTH-1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum_q       <= '0;
      r_carry_out_q <= 1'b0;
    end else if (en) begin
      r_sum_q       <= w_s;
      r_carry_out_q <= w_c[WIDTH];
    end
  end

  assign sum_q       = r_sum_q;
  assign carry_out_q = r_carry_out_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH 1, 8 and 16 with a queue scoreboard for the registered path.
// Overflow checks are included when FULL_ADDER_OVERFLOW_EN is defined.

module tb_full_adder;

  logic clk = 1'b0;
  logic reset;

  logic        a1, b1, ci1, en1, s1, co1, s1_q, co1_q;
  logic [7:0]  a8, b8, s8, s8_q;
  logic        ci8, en8, co8, co8_q;
  logic [15:0] a16, b16, s16, s16_q;
  logic        ci16, en16, co16, co16_q;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic ov1, ov8, ov16;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0]  q8[$];
  logic [16:0] q16[$];

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .sum(s1), .carry_out(co1), .a(a1), .b(b1), .carry_in(ci1),
    .clk(clk), .reset(reset), .en(en1), .sum_q(s1_q), .carry_out_q(co1_q)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .overflow(ov1)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .sum(s8), .carry_out(co8), .a(a8), .b(b8), .carry_in(ci8),
    .clk(clk), .reset(reset), .en(en8), .sum_q(s8_q), .carry_out_q(co8_q)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .overflow(ov8)
`endif
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .sum(s16), .carry_out(co16), .a(a16), .b(b16), .carry_in(ci16),
    .clk(clk), .reset(reset), .en(en16), .sum_q(s16_q), .carry_out_q(co16_q)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .overflow(ov16)
`endif
  );

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0]  exp1 [8];
    logic [8:0]  e8;
    logic [16:0] e16;
    exp1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    reset = 1'b1;
    {a1, b1, ci1, en1} = '0;
    a8 = '0; b8 = '0; ci8 = 1'b0; en8 = 1'b0;
    a16 = '0; b16 = '0; ci16 = 1'b0; en16 = 1'b0;

    #12;
    check("reset_sum_q8", {25'd0, s8_q}, 33'd0);
    check("reset_co_q8", {32'd0, co8_q}, 33'd0);
    check("reset_sum_q16", {17'd0, s16_q}, 33'd0);
    check("reset_co_q1", {32'd0, co1_q}, 33'd0);

    @(negedge clk);
    reset = 1'b0;

    // WIDTH=1 exhaustive truth table, one combination per 20 time units.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      {a1, b1, ci1} = v;
      #20;
      check($sformatf("w1_combo%0d", i), {31'd0, co1, s1}, {31'd0, exp1[i]});
`ifdef FULL_ADDER_OVERFLOW_EN
      check($sformatf("w1_ovf%0d", i), {32'd0, ov1}, {32'd0, co1 ^ v[0]});
`endif
    end

    // WIDTH=8 wrap and sign-boundary cases.
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; #1;
    check("w8_ff_01", {24'd0, co8, s8}, {24'd0, 1'b1, 8'h00});
`ifdef FULL_ADDER_OVERFLOW_EN
    check("w8_ff_01_ovf", {32'd0, ov8}, 33'd0);
`endif
    a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0; #1;
    check("w8_7f_01", {24'd0, co8, s8}, {24'd0, 1'b0, 8'h80});
`ifdef FULL_ADDER_OVERFLOW_EN
    check("w8_7f_01_ovf", {32'd0, ov8}, 33'd1);
`endif
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; #1;
    check("w8_ones_ones_1", {24'd0, co8, s8}, {24'd0, 1'b1, 8'hFF});
    a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1; #1;
    check("w8_ones_zero_1", {24'd0, co8, s8}, {24'd0, 1'b1, 8'h00});

    // Registered path: one load, then hold with en low.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1; en8 = 1'b1;
    #1;
    check("w8_comb_47", {24'd0, co8, s8}, {24'd0, 9'h047});
    q8.push_back(9'h047);
    @(posedge clk); #1;
    if (q8.size() == 0) begin
      check("w8_q_empty", 33'd1, 33'd0);
    end else begin
      e8 = q8.pop_front();
      check("w8_reg_47", {24'd0, co8_q, s8_q}, {24'd0, e8});
    end

    @(negedge clk);
    en8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a8 = 8'hF0 + 8'(k); b8 = 8'h3C; ci8 = k[0];
      @(posedge clk); #1;
      check($sformatf("w8_hold%0d", k), {24'd0, co8_q, s8_q}, {24'd0, 9'h047});
    end

    // Async reset between edges clears registers at once; combinational sum unaffected.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1; en8 = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("w8_async_rst", {24'd0, co8_q, s8_q}, 33'd0);
    check("w8_comb_in_rst", {24'd0, co8, s8}, {24'd0, 9'h047});
    @(posedge clk); #1;
    check("w8_rst_held", {24'd0, co8_q, s8_q}, 33'd0);
    @(negedge clk);
    reset = 1'b0;
    a8 = 8'hA5; b8 = 8'h5A; ci8 = 1'b1;
    q8.push_back({1'b0, 8'hA5} + {1'b0, 8'h5A} + 9'd1);
    @(posedge clk); #1;
    if (q8.size() == 0) begin
      check("w8_q_empty", 33'd1, 33'd0);
    end else begin
      e8 = q8.pop_front();
      check("w8_reg_after_rst", {24'd0, co8_q, s8_q}, {24'd0, e8});
    end

    // WIDTH=16 random vectors with registered scoreboard.
    @(negedge clk);
    en16 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom_range(0, 1));
      if (n == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1; end
      if (n == 1) begin a16 = 16'hFFFF; b16 = 16'h0000; ci16 = 1'b1; end
      e16 = {1'b0, a16} + {1'b0, b16} + {16'd0, ci16};
      #1;
      check($sformatf("w16_comb%0d", n), {16'd0, co16, s16}, {16'd0, e16});
      q16.push_back(e16);
      @(posedge clk); #1;
      if (q16.size() == 0) begin
        check("w16_q_empty", 33'd1, 33'd0);
      end else begin
        e16 = q16.pop_front();
        check($sformatf("w16_reg%0d", n), {16'd0, co16_q, s16_q}, {16'd0, e16});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
